// File: rtl/uart_tx.sv
// uart_tx: 8-N-1 UART transmitter with a clock-enable baud counter and a registered line.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (8-E-1).
module uart_tx #(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(BIT_CYCLES);

    generate
        if (BIT_CYCLES < 2) begin : g_bad_rate
            $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic bit_last, stop_last;
    assign bit_last  = cnt_q == CW'(BIT_CYCLES - 1);
    // The final stop-bit cycle is spent in IDLE with done high, so a held request
    // is accepted there and the next start bit follows without an idle gap.
    assign stop_last = cnt_q == CW'(BIT_CYCLES - 2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_last) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (stop_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_ready = state_q == IDLE;
    assign busy     = !tx_ready;
    assign tx       = tx_q;
    assign done     = done_q;
endmodule
